// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through its wr/data/busy handshake.
// Bytes leave strictly in push order, one outstanding UART write at a time.
module uart_tx_fifo #(
   parameter int ADDR_W       = 4,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_i,
   input  logic              push_i,
   input  logic [7:0]        push_dat_i,
   input  logic              flush_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic              overflow_o,
   input  logic              uart_busy_i,
   output logic              uart_wr_o,
   output logic [7:0]        uart_dat_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_ISSUE      = 2'd1;
   localparam logic [1:0] ST_WAIT_START = 2'd2;
   localparam logic [1:0] ST_WAIT_END   = 2'd3;

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              overflow_q, overflow_d;
   logic [1:0]        state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              uart_wr_q, uart_wr_d;
   logic [7:0]        uart_dat_q, uart_dat_d;
   logic              push_ok_s;
   logic              pop_s;

   // Push/pop qualification from the registered flags; flush overrides both.
   always_comb begin
      push_ok_s  = push_i & ~full_q & ~flush_i;
      pop_s      = (state_q == ST_IDLE) & ~empty_q & ~uart_busy_i & ~flush_i;
      overflow_d = push_i & full_q;
   end

   // Pointer, level and flag next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = {ADDR_W{1'b0}};
         rd_ptr_d = {ADDR_W{1'b0}};
         level_d  = {(ADDR_W + 1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
      full_d  = (level_d == LVL_FULL);
      empty_d = (level_d == {(ADDR_W + 1){1'b0}});
   end

   // Transmit handshake FSM; a missing busy response times out as "sent".
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      uart_wr_d  = 1'b0;
      uart_dat_d = uart_dat_q;
      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               uart_dat_d = mem_q[rd_ptr_q];
               uart_wr_d  = 1'b1;
               state_d    = ST_ISSUE;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            timer_d = {TMR_W{1'b0}};
            state_d = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (uart_busy_i) begin
               state_d = ST_WAIT_END;
            end else if (timer_q == TMR_LAST) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end
         ST_WAIT_END: begin
            if (!uart_busy_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_END;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Storage array; contents need no reset since level gates every read.
   always_ff @(posedge sys_clk_i) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         wr_ptr_q   <= {ADDR_W{1'b0}};
         rd_ptr_q   <= {ADDR_W{1'b0}};
         level_q    <= {(ADDR_W + 1){1'b0}};
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         state_q    <= ST_IDLE;
         timer_q    <= {TMR_W{1'b0}};
         uart_wr_q  <= 1'b0;
         uart_dat_q <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         timer_q    <= timer_d;
         uart_wr_q  <= uart_wr_d;
         uart_dat_q <= uart_dat_d;
      end
   end

   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign level_o    = level_q;
   assign overflow_o = overflow_q;
   assign uart_wr_o  = uart_wr_q;
   assign uart_dat_o = uart_dat_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple UART busy responder.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       sys_rst;
   logic       push;
   logic [7:0] push_dat;
   logic       flush;
   logic       full, empty, overflow;
   logic [4:0] level;
   logic       uart_busy;
   logic       uart_wr;
   logic [7:0] uart_dat;

   logic       hold;
   logic       model_en;
   int         busy_cnt;
   int         cyc;
   int         checks;
   int         failures;
   int         strobe_viol;
   int         level_viol;
   logic       prev_wr;
   logic [7:0] rx[$];
   int         wr_cyc[$];

   always #10 clk = ~clk;

   uart_tx_fifo #(.ADDR_W(4), .BUSY_TIMEOUT(8)) dut (
      .sys_clk_i  (clk),
      .sys_rst_i  (sys_rst),
      .push_i     (push),
      .push_dat_i (push_dat),
      .flush_i    (flush),
      .full_o     (full),
      .empty_o    (empty),
      .level_o    (level),
      .overflow_o (overflow),
      .uart_busy_i(uart_busy),
      .uart_wr_o  (uart_wr),
      .uart_dat_o (uart_dat)
   );

   // UART stand-in: 11 bit-times of 2 cycles each after every write strobe.
   assign uart_busy = hold | (busy_cnt != 0);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sys_rst) busy_cnt <= 0;
      else if (uart_wr && model_en) busy_cnt <= 22;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   always @(negedge clk) begin
      if (uart_wr) begin
         rx.push_back(uart_dat);
         wr_cyc.push_back(cyc);
      end
      if (uart_wr && prev_wr) strobe_viol++;
      if (level > 5'd16) level_viol++;
      prev_wr = uart_wr;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [7:0] b);
      push = 1'b1;
      push_dat = b;
      tick();
      push = 1'b0;
   endtask

   task automatic drain(input int n, input int budget);
      int k = 0;
      while ((rx.size() < n || uart_busy) && k < budget) begin
         tick();
         k++;
      end
      check_eq("drain_in_time", 32'(k < budget), 32'd1);
      repeat (4) tick();
   endtask

   initial begin
      int snap;
      checks = 0; failures = 0; strobe_viol = 0; level_viol = 0;
      cyc = 0; busy_cnt = 0; prev_wr = 1'b0;
      sys_rst = 1'b1; push = 1'b0; push_dat = 8'h00; flush = 1'b0;
      hold = 1'b0; model_en = 1'b1;
      repeat (3) tick();
      check_eq("rst_level", level, 5'd0);
      check_eq("rst_empty", empty, 1'b1);
      check_eq("rst_full", full, 1'b0);
      check_eq("rst_wr", uart_wr, 1'b0);
      check_eq("rst_dat", uart_dat, 8'h00);
      sys_rst = 1'b0;
      tick();

      // 1: single byte, two-cycle latency
      push_one(8'hA5);
      check_eq("t1_wr_n1", uart_wr, 1'b0);
      tick();
      check_eq("t1_wr_n2", uart_wr, 1'b1);
      check_eq("t1_dat", uart_dat, 8'hA5);
      check_eq("t1_empty", empty, 1'b1);
      tick();
      check_eq("t1_wr_off", uart_wr, 1'b0);
      drain(1, 200);
      check_eq("t1_cnt", rx.size(), 1);
      check_eq("t1_byte", rx[0], 8'hA5);

      // 2: fill to full, overflow, ordered drain
      rx.delete();
      hold = 1'b1;
      for (int i = 0; i < 16; i++) push_one(8'(i));
      check_eq("t2_full", full, 1'b1);
      check_eq("t2_level", level, 5'd16);
      push_one(8'hFF);
      check_eq("t2_ovf", overflow, 1'b1);
      check_eq("t2_level_ovf", level, 5'd16);
      tick();
      check_eq("t2_ovf_pulse", overflow, 1'b0);
      hold = 1'b0;
      drain(16, 2000);
      check_eq("t2_cnt", rx.size(), 16);
      for (int i = 0; i < 16; i++) check_eq($sformatf("t2_byte%0d", i), rx[i], 8'(i));
      check_eq("t2_empty", empty, 1'b1);

      // 3: interleaved push/drain across pointer wrap
      rx.delete();
      for (int i = 0; i < 20; i++) begin
         push_one(8'h30 + 8'(i));
         repeat (9) tick();
      end
      drain(20, 3000);
      check_eq("t3_cnt", rx.size(), 20);
      for (int i = 0; i < 20; i++) check_eq($sformatf("t3_byte%0d", i), rx[i], 8'h30 + 8'(i));
      check_eq("t3_level_bound", level_viol, 0);

      // 4: busy never rises, timeout then next byte
      rx.delete();
      wr_cyc.delete();
      model_en = 1'b0;
      push_one(8'hC1);
      push_one(8'hC2);
      drain(2, 200);
      check_eq("t4_cnt", rx.size(), 2);
      check_eq("t4_b0", rx[0], 8'hC1);
      check_eq("t4_b1", rx[1], 8'hC2);
      check_eq("t4_gap", wr_cyc[1] - wr_cyc[0], 10);
      model_en = 1'b1;

      // 5: flush with coincident push while a byte is in flight
      rx.delete();
      for (int i = 0; i < 5; i++) push_one(8'h50 + 8'(i));
      check_eq("t5_level_pre", level, 5'd4);
      flush = 1'b1;
      push_one(8'h77);
      flush = 1'b0;
      check_eq("t5_level", level, 5'd0);
      check_eq("t5_empty", empty, 1'b1);
      drain(1, 200);
      repeat (10) tick();
      check_eq("t5_cnt", rx.size(), 1);
      check_eq("t5_byte", rx[0], 8'h50);

      // 6: reset during WAIT_END with bytes queued
      rx.delete();
      for (int i = 0; i < 4; i++) push_one(8'h60 + 8'(i));
      repeat (3) tick();
      check_eq("t6_level_pre", level, 5'd3);
      check_eq("t6_busy_pre", uart_busy, 1'b1);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check_eq("t6_level", level, 5'd0);
      check_eq("t6_empty", empty, 1'b1);
      check_eq("t6_full", full, 1'b0);
      check_eq("t6_ovf", overflow, 1'b0);
      check_eq("t6_wr", uart_wr, 1'b0);
      check_eq("t6_dat", uart_dat, 8'h00);
      snap = rx.size();
      repeat (40) tick();
      check_eq("t6_no_wr", rx.size(), snap);
      push_one(8'h9A);
      drain(snap + 1, 200);
      check_eq("t6_new_byte", rx[snap], 8'h9A);

      check_eq("strobe_width", strobe_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
